// File: rtl/seg7_scan_if.sv
// Display-data and scan-output bundle between the application datapath and seg7_scan_ctrl.
// The master drives the display data; the slave (the controller) drives the pins.
interface seg7_scan_if #(
    parameter int DIGITS = 8
);
    logic                  EN;
    logic                  LOAD;
    logic [4*DIGITS-1:0]   HEX_IN;
    logic [DIGITS-1:0]     DIG_EN;
    logic [DIGITS-1:0]     DP_IN;
    logic [DIGITS-1:0]     BLINK;
    logic                  LZB;
    logic [3:0]            BRIGHT;
    logic [DIGITS-1:0]     AN;
    logic [7:0]            CAT;
    logic                  FRAME;

    modport master (
        output EN, LOAD, HEX_IN, DIG_EN, DP_IN, BLINK, LZB, BRIGHT,
        input  AN, CAT, FRAME
    );

    modport slave (
        input  EN, LOAD, HEX_IN, DIG_EN, DP_IN, BLINK, LZB, BRIGHT,
        output AN, CAT, FRAME
    );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// N-digit multiplexed 7-segment scanner: prescaled digit scan, double-buffered data,
// leading-zero blanking, per-digit blink and 16-level PWM brightness.
module seg7_scan_ctrl #(
    parameter int DIGITS       = 8,
    parameter int SCAN_DIV     = 1024,
    parameter int BLINK_FRAMES = 64,
    parameter int AN_ACT_LOW   = 1,
    parameter int SEG_ACT_LOW  = 1
) (
    input  logic       CLK,
    input  logic       RST,
    seg7_scan_if.slave bus
);
    localparam int PRE_W     = $clog2(SCAN_DIV);
    localparam int IDX_W     = $clog2(DIGITS);
    localparam int FC_W      = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int DUTY_STEP = SCAN_DIV / 16;
    localparam logic [DIGITS-1:0] AN_OFF  = (AN_ACT_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
    localparam logic [7:0]        CAT_OFF = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;

    function automatic logic [6:0] hex_font(input logic [3:0] nib);
        case (nib)
            4'h0:    hex_font = 7'h3F;
            4'h1:    hex_font = 7'h06;
            4'h2:    hex_font = 7'h5B;
            4'h3:    hex_font = 7'h4F;
            4'h4:    hex_font = 7'h66;
            4'h5:    hex_font = 7'h6D;
            4'h6:    hex_font = 7'h7D;
            4'h7:    hex_font = 7'h07;
            4'h8:    hex_font = 7'h7F;
            4'h9:    hex_font = 7'h6F;
            4'hA:    hex_font = 7'h77;
            4'hB:    hex_font = 7'h7C;
            4'hC:    hex_font = 7'h39;
            4'hD:    hex_font = 7'h5E;
            4'hE:    hex_font = 7'h79;
            default: hex_font = 7'h71;
        endcase
    endfunction

    logic [PRE_W-1:0]    pre_p0;
    logic [IDX_W-1:0]    idx_p0;
    logic [FC_W-1:0]     fcnt_p0;
    logic                bph_p0;
    logic                tick_p0;
    logic                wrap_p0;

    logic [4*DIGITS-1:0] pend_hex, act_hex;
    logic [DIGITS-1:0]   pend_en, pend_dp, pend_bl;
    logic [DIGITS-1:0]   act_en, act_dp, act_bl;

    logic [DIGITS-1:0]   lz_p0;
    logic                nz_seen;
    logic [3:0]          nib_p0;
    logic                blink_off_p0;
    logic                seg_on_p0;
    logic [PRE_W:0]      duty_lim_p0;
    logic [DIGITS-1:0]   an_p0;
    logic [7:0]          cat_p0;

    logic [DIGITS-1:0]   an_p1;
    logic [7:0]          cat_p1;
    logic                frame_p1;

    assign tick_p0 = bus.EN && (pre_p0 == PRE_W'(SCAN_DIV - 1));
    assign wrap_p0 = tick_p0 && (idx_p0 == IDX_W'(DIGITS - 1));

    // Stage p0: scan position, blink phase and display buffers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pre_p0  <= '0;
            idx_p0  <= '0;
            fcnt_p0 <= '0;
            bph_p0  <= 1'b0;
        end else if (tick_p0) begin
            pre_p0 <= '0;
            idx_p0 <= wrap_p0 ? '0 : idx_p0 + 1'b1;
            if (wrap_p0) begin
                if (fcnt_p0 == FC_W'(BLINK_FRAMES - 1)) begin
                    fcnt_p0 <= '0;
                    bph_p0  <= ~bph_p0;
                end else begin
                    fcnt_p0 <= fcnt_p0 + 1'b1;
                end
            end
        end else if (bus.EN) begin
            pre_p0 <= pre_p0 + 1'b1;
        end
    end

    // A LOAD landing on the boundary bypasses pending so it is shown in the new frame.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pend_hex <= '0;
            pend_en  <= '0;
            pend_dp  <= '0;
            pend_bl  <= '0;
            act_hex  <= '0;
            act_en   <= '0;
            act_dp   <= '0;
            act_bl   <= '0;
        end else begin
            if (bus.LOAD) begin
                pend_hex <= bus.HEX_IN;
                pend_en  <= bus.DIG_EN;
                pend_dp  <= bus.DP_IN;
                pend_bl  <= bus.BLINK;
            end
            if (wrap_p0) begin
                act_hex <= bus.LOAD ? bus.HEX_IN : pend_hex;
                act_en  <= bus.LOAD ? bus.DIG_EN : pend_en;
                act_dp  <= bus.LOAD ? bus.DP_IN  : pend_dp;
                act_bl  <= bus.LOAD ? bus.BLINK  : pend_bl;
            end
        end
    end

    // lz_p0[i] is set when every nibble from the top digit down to i is zero; digit 0 never qualifies.
    always_comb begin
        lz_p0   = '0;
        nz_seen = 1'b0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            nz_seen  = nz_seen | (act_hex[4*i +: 4] != 4'h0);
            lz_p0[i] = ~nz_seen;
        end
    end

    always_comb begin
        nib_p0       = act_hex[{idx_p0, 2'b00} +: 4];
        blink_off_p0 = bph_p0 && act_bl[idx_p0];
        seg_on_p0    = act_en[idx_p0] && !blink_off_p0 && !(bus.LZB && lz_p0[idx_p0]);
        cat_p0       = {act_dp[idx_p0] && act_en[idx_p0] && !blink_off_p0,
                        seg_on_p0 ? hex_font(nib_p0) : 7'h00};
        duty_lim_p0  = (PRE_W + 1)'((32'(bus.BRIGHT) + 32'd1) * 32'(DUTY_STEP));
        an_p0        = '0;
        if (bus.EN && ({1'b0, pre_p0} < duty_lim_p0))
            an_p0[idx_p0] = 1'b1;
    end

    // Stage p1: pin registers, polarity applied here only
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            an_p1    <= AN_OFF;
            cat_p1   <= CAT_OFF;
            frame_p1 <= 1'b0;
        end else begin
            an_p1    <= an_p0 ^ AN_OFF;
            cat_p1   <= cat_p0 ^ CAT_OFF;
            frame_p1 <= wrap_p0;
        end
    end

    assign bus.AN    = an_p1;
    assign bus.CAT   = cat_p1;
    assign bus.FRAME = frame_p1;
endmodule
